// File: rtl/audio_dac_serializer_if.sv
// Sample write handshake between the audio top level and the DAC serializer.
// The master offers a signed stereo pair with write; the slave reports
// write_ready while it has room to accept another pair.
interface audio_dac_serializer_if #(
    parameter int DATA_WIDTH = 24
);
    logic                         write;
    logic signed [DATA_WIDTH-1:0] writedata_left;
    logic signed [DATA_WIDTH-1:0] writedata_right;
    logic                         write_ready;

    modport master (
        output write,
        output writedata_left,
        output writedata_right,
        input  write_ready
    );

    modport slave (
        input  write,
        input  writedata_left,
        input  writedata_right,
        output write_ready
    );
endinterface

// File: rtl/audio_dac_serializer.sv
// Codec-side DAC serializer: buffers stereo pairs in a small FIFO and shifts
// them out MSB-first in left-justified format, slaved to the codec-mastered
// AUD_BCLK / AUD_DACLRCK which are synchronized into the CLOCK_50 domain.
module audio_dac_serializer #(
    parameter int DATA_WIDTH  = 24,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          CLOCK_50,
    input  logic                          reset,
    audio_dac_serializer_if.slave         wr_if,
    input  logic                          AUD_BCLK,
    input  logic                          AUD_DACLRCK,
    output logic                          AUD_DACDAT,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          underflow
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BCNT_W = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {
        WAIT_FRAME = 2'd0,
        LEFT       = 2'd1,
        RIGHT      = 2'd2
    } state_t;

    state_t state;

    // Synchronizer chains; the history flop sits after the last stage so
    // edges are detected only on fully synchronized values.
    logic [SYNC_STAGES-1:0] bclk_sync;
    logic [SYNC_STAGES-1:0] lr_sync;
    logic                   bclk_hist;
    logic                   lr_hist;
    logic                   bclk_fall;
    logic                   lr_rise;
    logic                   lr_fall;

    // FIFO storage and bookkeeping
    logic signed [DATA_WIDTH-1:0] mem_left  [FIFO_DEPTH];
    logic signed [DATA_WIDTH-1:0] mem_right [FIFO_DEPTH];
    logic [PTR_W-1:0]             wr_ptr;
    logic [PTR_W-1:0]             rd_ptr;
    logic [CNT_W-1:0]             count_next;
    logic                         fifo_empty;
    logic                         push;
    logic                         pop;

    // Serializer state
    logic signed [DATA_WIDTH-1:0] shift_reg;
    logic signed [DATA_WIDTH-1:0] right_hold;
    logic [BCNT_W-1:0]            bit_cnt;
    logic                         enter_left;
    logic                         enter_right;

    // Synchronizers are left free-running through reset so a level that
    // was already high is never mistaken for a fresh edge afterwards.
    always_ff @(posedge CLOCK_50) begin
        bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], AUD_BCLK};
        lr_sync   <= {lr_sync[SYNC_STAGES-2:0], AUD_DACLRCK};
        bclk_hist <= bclk_sync[SYNC_STAGES-1];
        lr_hist   <= lr_sync[SYNC_STAGES-1];
    end

    assign bclk_fall = bclk_hist & ~bclk_sync[SYNC_STAGES-1];
    assign lr_rise   = ~lr_hist & lr_sync[SYNC_STAGES-1];
    assign lr_fall   = lr_hist & ~lr_sync[SYNC_STAGES-1];

    // A falling LRCK seen while idle is ignored so output always opens on a left word.
    assign enter_left  = lr_rise && ((state == WAIT_FRAME) || (state == RIGHT));
    assign enter_right = lr_fall && (state == LEFT);

    assign fifo_empty = (fifo_count == '0);
    assign push       = wr_if.write && wr_if.write_ready;
    assign pop        = enter_left && !fifo_empty;

    // Next occupancy; a simultaneous push and pop cancel out.
    always_comb begin
        count_next = fifo_count;
        if (push && !pop) begin
            count_next = fifo_count + CNT_W'(1);
        end else if (!push && pop) begin
            count_next = fifo_count - CNT_W'(1);
        end
    end

    // Sample storage carries no reset; only the pointers define validity.
    always_ff @(posedge CLOCK_50) begin
        if (push) begin
            mem_left[wr_ptr]  <= wr_if.writedata_left;
            mem_right[wr_ptr] <= wr_if.writedata_right;
        end
    end

    // FIFO pointers, occupancy and the registered ready flag.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            fifo_count        <= '0;
            wr_if.write_ready <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            fifo_count        <= count_next;
            wr_if.write_ready <= (count_next < CNT_W'(FIFO_DEPTH));
        end
    end

    // Right sample of the popped pair waits here until LRCK falls.
    always_ff @(posedge CLOCK_50) begin
        if (!reset && enter_left) begin
            right_hold <= fifo_empty ? '0 : mem_right[rd_ptr];
        end
    end

    // Frame FSM and shifter; an LRCK load takes priority over a coincident BCLK shift.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state     <= WAIT_FRAME;
            shift_reg <= '0;
            bit_cnt   <= '0;
            underflow <= 1'b0;
        end else begin
            underflow <= 1'b0;
            if (enter_left) begin
                state   <= LEFT;
                bit_cnt <= BCNT_W'(DATA_WIDTH);
                if (fifo_empty) begin
                    shift_reg <= '0;
                    underflow <= 1'b1;
                end else begin
                    shift_reg <= mem_left[rd_ptr];
                end
            end else if (enter_right) begin
                state     <= RIGHT;
                shift_reg <= right_hold;
                bit_cnt   <= BCNT_W'(DATA_WIDTH);
            end else if (bclk_fall && (state != WAIT_FRAME)) begin
                if (bit_cnt > BCNT_W'(1)) begin
                    shift_reg <= {shift_reg[DATA_WIDTH-2:0], 1'b0};
                    bit_cnt   <= bit_cnt - BCNT_W'(1);
                end else if (bit_cnt == BCNT_W'(1)) begin
                    // Word finished: pad the rest of the channel half with zeros.
                    shift_reg <= '0;
                    bit_cnt   <= '0;
                end
            end
        end
    end

    assign AUD_DACDAT = shift_reg[DATA_WIDTH-1];

endmodule

// File: doc/audio_dac_serializer.md
Name: audio_dac_serializer

Overview:
- Codec-side responder for the sample write handshake used by the audio top level (write_ready / write / writedata_left / writedata_right).
- Buffers stereo sample pairs in a small FIFO and serializes them onto AUD_DACDAT in left-justified format, slaved to the codec-mastered AUD_BCLK and AUD_DACLRCK.
- Replaces the DAC half of audio_codec so the filter output path can be verified and tuned independently of the ADC path.

Parameters:
- DATA_WIDTH, 24, bits per channel sample.
- FIFO_DEPTH, 4, stereo pairs buffered; power of 2, minimum 2.
- SYNC_STAGES, 2, synchronizer flops on AUD_BCLK and AUD_DACLRCK; minimum 2.

Ports:
- CLOCK_50  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- write  in  1  push request; sampled only while write_ready=1.
- writedata_left  in  DATA_WIDTH  signed left sample; captured with write.
- writedata_right  in  DATA_WIDTH  signed right sample; captured with write.
- write_ready  out  1  FIFO not full.
- AUD_BCLK  in  1  codec bit clock, asynchronous.
- AUD_DACLRCK  in  1  codec frame clock, asynchronous; 1 = left channel.
- AUD_DACDAT  out  1  serial data to codec.
- fifo_count  out  log2(FIFO_DEPTH)+1  pairs currently buffered.
- underflow  out  1  one-cycle pulse when a frame starts with the FIFO empty.

Behaviour:
- Reset: while reset=1, on every clock: FIFO emptied, fifo_count=0, write_ready=0, AUD_DACDAT=0, underflow=0, shift register=0, bit counter=0, FSM=WAIT_FRAME. Cycle after deassertion: write_ready=1. Reset mid-frame abandons the current word immediately; output resumes only at the next LRCK rising edge.
- Handshake: push occurs iff write && write_ready on a clock edge; writes while write_ready=0 are ignored with no side effects. write_ready = (fifo_count < FIFO_DEPTH), registered, reflecting the count after the current cycle's push/pop. A push and a pop in the same cycle leave fifo_count unchanged; both take effect.
- Synchronization: AUD_BCLK and AUD_DACLRCK each pass through SYNC_STAGES flops, plus one history flop for edge detection. Events: bclk_fall, lr_rise, lr_fall, each a single-cycle strobe.
- FSM states:
  - WAIT_FRAME: idle, AUD_DACDAT=0. lr_rise -> LEFT.
  - LEFT: lr_fall -> RIGHT.
  - RIGHT: lr_rise -> LEFT.
- Entering LEFT on lr_rise:
  - FIFO non-empty: pop one pair, load left into the shift register, hold right in a right-hold register.
  - FIFO empty: load 0 into both and pulse underflow for 1 cycle.
  - In both cases, reset the bit counter to DATA_WIDTH.
- Entering RIGHT on lr_fall: load the right-hold register into the shift register; no pop; bit counter reset to DATA_WIDTH.
- Serialization (left-justified):
  - AUD_DACDAT = shift register MSB, valid in the cycle after the load; the MSB is therefore stable before the first BCLK rising edge of the channel.
  - Each bclk_fall with bit counter > 1 shifts left, inserting 0, and decrements the counter.
  - When the counter reaches 1, the next bclk_fall drives AUD_DACDAT=0; it stays 0 for any remaining BCLKs in that channel half.
- Simultaneous bclk_fall and an LRCK edge in the same cycle: the LRCK load wins and the shift is discarded.
- An LRCK edge in WAIT_FRAME other than lr_rise is ignored, so the first output is always a left word.
- Timing: BCLK high and low times must each be ≥ SYNC_STAGES+3 CLOCK_50 periods; faster BCLK is unsupported.

Test Plan:
- Bench model: BCLK period 16 CLOCK_50 cycles, 32 BCLKs per channel.
- Reset then idle: reset=1 for 5 cycles -> write_ready=0 and AUD_DACDAT=0 during reset; write_ready=1 the cycle after; the first lr_rise with an empty FIFO gives one underflow pulse and 64 zero bits.
- Single pair: write left=24'h800001, right=24'h7FFFFE before the first lr_rise -> captured left bits MSB-first = 800001, right bits = 7FFFFE, bits 25-32 of each half = 0, fifo_count 1→0 at lr_rise.
- Fill: 4 back-to-back writes with no frame activity -> fifo_count=4, write_ready=0; a 5th write is ignored; after 4 frames the output sequence matches the first 4 pairs exactly and the 5th pair never appears.
- Simultaneous push/pop: with fifo_count=2, assert write in the same cycle as the lr_rise pop -> fifo_count stays 2 and write_ready stays 1.
- Reset mid-frame: assert reset at bit 10 of a left word holding 2 pairs -> AUD_DACDAT=0 the next cycle, fifo_count=0, no output until the next lr_rise, which underflows.
